// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encodings, default sizing,
// and the hold-counter width helper.
package rr_arbiter16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1
    } arb_state_t;

    localparam int DEF_N        = 16;
    localparam int DEF_IDXW     = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Width needed to count up to max_hold; a disabled timeout still keeps one bit.
    function automatic int hold_w(input int max_hold);
        return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter16_onehot_dec.sv
// Index-to-one-hot decoder with enable; output is all-zero when disabled.
module onehot_dec #(
    parameter int IDXW = 4
) (
    input  logic [IDXW-1:0]    in,
    input  logic               en,
    output logic [2**IDXW-1:0] out
);

    localparam int OW = 2**IDXW;

    always_comb begin
        out = '0;
        if (en) out = OW'(1) << in;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter with grant hold, optional hold timeout and a mandatory
// dead cycle between grants. All outputs come straight from registers or the decoder.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int IDXW     = DEF_IDXW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            preempt
);

    localparam int HCW = hold_w(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);

    arb_state_t      state;
    logic [IDXW-1:0] last_ptr;
    logic [HCW-1:0]  hold_cnt;
    logic [IDXW-1:0] winner;
    logic            any_req;

    // Rotate so the slot after last_ptr sits at bit 0, take the lowest set bit,
    // then add the rotation back; index arithmetic wraps naturally since N = 2**IDXW.
    function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0] r,
                                                 input logic [IDXW-1:0] lp);
        logic [IDXW-1:0] base;
        logic [N-1:0]    rot;
        logic [IDXW-1:0] k;
        base = lp + IDXW'(1);
        for (int i = 0; i < N; i++) rot[i] = r[base + IDXW'(i)];
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) k = IDXW'(i);
        end
        return base + k;
    endfunction

    always_comb begin
        any_req = |req;
        winner  = rr_pick(req, last_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            last_ptr  <= IDXW'(N - 1);
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_GRANT;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        last_ptr  <= winner;
                        hold_cnt  <= HCW'(1);
                    end
                end
                ST_GRANT: begin
                    if (!req[gnt_idx]) begin
                        state     <= ST_IDLE;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIM) begin
                        state     <= ST_IDLE;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        preempt   <= 1'b1;
                    end else if (hold_cnt != {HCW{1'b1}}) begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt_idx   <= '0;
                    gnt_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

    onehot_dec #(.IDXW(IDXW)) u_gnt_dec (
        .in  (gnt_idx),
        .en  (gnt_valid),
        .out (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed-vector bench for rr_arbiter16: reset, rotation, timeout, wrap,
// late request and mid-grant reset scenarios.
module tb_rr_arbiter16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    int total = 0;
    int bad   = 0;

    rr_arbiter16 #(.N(16), .IDXW(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 16'hFFFF;
        tick();
        tick();
        total++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || preempt !== 1'b0 || gnt_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%h valid=%b preempt=%b idx=%0d, want 0000/0/0/0",
                     gnt, gnt_valid, preempt, gnt_idx);
        end
        rst = 1'b0;
        tick();
        total++;
        if (gnt !== 16'h0001 || gnt_valid !== 1'b1 || gnt_idx !== 4'd0) begin
            bad++;
            $display("FAIL reset_first_grant: gnt=%h valid=%b idx=%0d, want 0001/1/0",
                     gnt, gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_idx [4];
        logic [15:0] one;
        exp_idx = '{4'd0, 4'd2, 4'd15, 4'd0};
        do_reset();
        req = 16'h8005;
        for (int g = 0; g < 4; g++) begin
            tick();
            one = 16'h0001 << exp_idx[g];
            total++;
            if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx[g] || gnt !== one) begin
                bad++;
                $display("FAIL rotation_grant%0d: idx=%0d gnt=%h valid=%b, want idx=%0d gnt=%h valid=1",
                         g, gnt_idx, gnt, gnt_valid, exp_idx[g], one);
            end
            tick();
            req = 16'h8005 & ~one;
            tick();
            total++;
            if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin
                bad++;
                $display("FAIL rotation_dead%0d: gnt=%h valid=%b, want 0000/0", g, gnt, gnt_valid);
            end
            req = 16'h8005;
        end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req = 16'h0010;
        tick();
        cnt = 0;
        while (gnt_valid === 1'b1 && gnt_idx === 4'd4 && cnt < 20) begin
            cnt++;
            tick();
        end
        total++;
        if (cnt != 8) begin
            bad++;
            $display("FAIL timeout_hold_len: held %0d cycles, want 8", cnt);
        end
        total++;
        if (preempt !== 1'b1 || gnt !== 16'h0000) begin
            bad++;
            $display("FAIL timeout_preempt: preempt=%b gnt=%h, want 1/0000", preempt, gnt);
        end
        tick();
        total++;
        if (preempt !== 1'b0 || gnt_valid !== 1'b1 || gnt_idx !== 4'd4 || gnt !== 16'h0010) begin
            bad++;
            $display("FAIL timeout_regrant: preempt=%b valid=%b idx=%0d gnt=%h, want 0/1/4/0010",
                     preempt, gnt_valid, gnt_idx, gnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h8000;
        tick();
        total++;
        if (gnt_idx !== 4'd15 || gnt !== 16'h8000) begin
            bad++;
            $display("FAIL wrap_setup: idx=%0d gnt=%h, want 15/8000", gnt_idx, gnt);
        end
        req = 16'h0000;
        tick();
        req = 16'h8001;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 4'd0 || gnt !== 16'h0001) begin
            bad++;
            $display("FAIL wrap_grant: valid=%b idx=%0d gnt=%h, want 1/0/0001", gnt_valid, gnt_idx, gnt);
        end
    endtask

    task automatic test_late_request();
        do_reset();
        req = 16'h0008;
        tick();
        req = 16'h000A;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gnt_idx !== 4'd3 || gnt !== 16'h0008 || gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL late_hold%0d: idx=%0d gnt=%h valid=%b, want 3/0008/1",
                         i, gnt_idx, gnt, gnt_valid);
            end
        end
        req = 16'h0002;
        tick();
        total++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL late_dead: gnt=%h valid=%b, want 0000/0", gnt, gnt_valid);
        end
        tick();
        total++;
        if (gnt_idx !== 4'd1 || gnt !== 16'h0002 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL late_grant: idx=%0d gnt=%h valid=%b, want 1/0002/1", gnt_idx, gnt, gnt_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 16'h0200;
        tick();
        total++;
        if (gnt_idx !== 4'd9 || gnt !== 16'h0200) begin
            bad++;
            $display("FAIL midrst_setup: idx=%0d gnt=%h, want 9/0200", gnt_idx, gnt);
        end
        rst = 1'b1;
        tick();
        total++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
            bad++;
            $display("FAIL midrst_drop: gnt=%h valid=%b preempt=%b, want 0000/0/0", gnt, gnt_valid, preempt);
        end
        rst = 1'b0;
        req = 16'h0202;
        tick();
        total++;
        if (gnt_idx !== 4'd1 || gnt !== 16'h0002 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_regrant: idx=%0d gnt=%h valid=%b, want 1/0002/1", gnt_idx, gnt, gnt_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_timeout();
        test_wrap();
        test_late_request();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
